fir_load_ctrl: RTL and testbench

- Initiator for the FIR filter's memory-load and run interface; replaces the bench-driven load sequence in silicon.
- Accepts a word stream of 64 coefficients followed by 16384 samples, writes them into CMEM then IMEM, releases the FIR and starts it.
- Forwards every valid FIR output word to a result stream and reports completion when the FIR asserts Done.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_load_addr_cnt.sv | 21 ++
 rtl/fir_load_ctrl.sv | 133 +++++++++++++
 tb/tb_fir_load_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR load/run controller.
package fir_pkg;
    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int NCOEF = 64;
    localparam int NSAMP = 16384;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_C = 3'd1,
        LOAD_I = 3'd2,
        RUN    = 3'd3,
        FIN    = 3'd4
    } state_t;
endpackage

// File: rtl/fir_load_addr_cnt.sv
// FIR write-address counter with clear priority and terminal-count compare.
module fir_load_addr_cnt #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    input  logic [AW-1:0] limit,
    output logic [AW-1:0] cnt,
    output logic          tc
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == limit);
endmodule

// File: rtl/fir_load_ctrl.sv
// Streams NCOEF coefficients into CMEM and NSAMP samples into IMEM, then runs
// the FIR and forwards its results until Done.
module fir_load_ctrl
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] fir_addr,
    output logic [DW-1:0] fir_din,
    output logic          fir_cload,
    output logic          fir_dload,
    output logic          fir_s,
    output logic          fir_rstn,
    input  logic [DW-1:0] fir_dout,
    input  logic          fir_valid,
    input  logic          fir_Done,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);
    localparam logic [AW-1:0] LIM_C = AW'(NCOEF - 1);
    localparam logic [AW-1:0] LIM_I = AW'(NSAMP - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          tc;
    logic          accept;
    logic          loading;
    logic          cnt_clr;
    logic [AW-1:0] limit;

    assign loading = (state == LOAD_C) || (state == LOAD_I);
    assign accept  = in_valid && in_ready && loading;
    assign limit   = (state == LOAD_I) ? LIM_I : LIM_C;
    // IMEM addressing restarts at 0 once the coefficient phase completes.
    assign cnt_clr = (state == IDLE) || (accept && tc && state == LOAD_C);

    fir_load_addr_cnt #(.AW(AW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clr   (cnt_clr),
        .limit (limit),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            fir_addr  <= '0;
            fir_din   <= '0;
            fir_cload <= 1'b1;
            fir_dload <= 1'b1;
            fir_s     <= 1'b0;
            fir_rstn  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fir_cload <= 1'b1;
            fir_dload <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b0;
                    if (start) begin
                        state    <= LOAD_C;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD_C: begin
                    in_ready <= !(accept && tc);
                    if (accept) begin
                        fir_addr  <= cnt;
                        fir_din   <= in_data;
                        fir_cload <= 1'b0;
                        if (tc)
                            state <= LOAD_I;
                    end
                end
                LOAD_I: begin
                    in_ready <= !(accept && tc);
                    if (accept) begin
                        fir_addr  <= cnt;
                        fir_din   <= in_data;
                        fir_dload <= 1'b0;
                        if (tc)
                            state <= RUN;
                    end
                end
                RUN: begin
                    in_ready <= 1'b0;
                    // First RUN cycle carries the last IMEM strobe; release the FIR after it.
                    if (!fir_s) begin
                        fir_s    <= 1'b1;
                        fir_rstn <= 1'b1;
                    end else begin
                        if (fir_valid) begin
                            out_data  <= fir_dout;
                            out_valid <= 1'b1;
                        end
                        if (fir_Done) begin
                            state    <= FIN;
                            done     <= 1'b1;
                            fir_s    <= 1'b0;
                            fir_rstn <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_load_ctrl.sv
// Scoreboard bench for fir_load_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_fir_load_ctrl;
    import fir_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] fir_addr;
    logic [DW-1:0] fir_din;
    logic          fir_cload, fir_dload, fir_s, fir_rstn;
    logic [DW-1:0] fir_dout = '0;
    logic          fir_valid = 1'b0;
    logic          fir_Done = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid, busy, done;

    fir_load_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fir_addr(fir_addr), .fir_din(fir_din),
        .fir_cload(fir_cload), .fir_dload(fir_dload),
        .fir_s(fir_s), .fir_rstn(fir_rstn),
        .fir_dout(fir_dout), .fir_valid(fir_valid), .fir_Done(fir_Done),
        .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum int {P_IN_READY, P_ADDR, P_DIN, P_CLOAD, P_DLOAD, P_S, P_RSTN,
                      P_ODATA, P_OVALID, P_BUSY, P_DONE} sig_e;
    typedef struct { string name; sig_e sig; int exp; } probe_t;
    typedef struct { bit c; int addr; int din; } wr_t;

    probe_t        pr_q[$];
    wr_t           wr_q[$];
    logic [DW-1:0] res_q[$];
    bit            done_q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    bit            end_req = 1'b0;

    function automatic int sample(sig_e s);
        case (s)
            P_IN_READY: return int'(in_ready);
            P_ADDR:     return int'(fir_addr);
            P_DIN:      return int'(fir_din);
            P_CLOAD:    return int'(fir_cload);
            P_DLOAD:    return int'(fir_dload);
            P_S:        return int'(fir_s);
            P_RSTN:     return int'(fir_rstn);
            P_ODATA:    return int'(out_data);
            P_OVALID:   return int'(out_valid);
            P_BUSY:     return int'(busy);
            P_DONE:     return int'(done);
            default:    return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the only process that evaluates comparisons.
    always @(negedge clk) begin
        while (pr_q.size() > 0) begin
            probe_t p;
            p = pr_q.pop_front();
            chk(p.name, sample(p.sig), p.exp);
        end
        if (fir_cload !== 1'b1 || fir_dload !== 1'b1) begin
            if (wr_q.size() == 0)
                chk("unexpected_write_strobe", int'({fir_cload, fir_dload}), 3);
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_cload", int'(fir_cload), e.c ? 0 : 1);
                chk("wr_dload", int'(fir_dload), e.c ? 1 : 0);
                chk("wr_addr",  int'(fir_addr), e.addr);
                chk("wr_din",   int'(fir_din), e.din);
            end
        end
        if (out_valid !== 1'b0) begin
            if (res_q.size() == 0)
                chk("unexpected_out_valid", int'(out_valid), 0);
            else
                chk("out_data", int'(out_data), int'(res_q.pop_front()));
        end
        if (done !== 1'b0) begin
            if (done_q.size() == 0)
                chk("unexpected_done", int'(done), 0);
            else
                chk("done_pulse", int'(done), int'(done_q.pop_front()));
        end
        if (end_req) begin
            chk("writes_outstanding", wr_q.size(), 0);
            chk("results_outstanding", res_q.size(), 0);
            chk("done_outstanding", done_q.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic probe(input string n, input sig_e s, input int e);
        pr_q.push_back('{n, s, e});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe_reset_vals(input string tag);
        probe({tag, "_in_ready"},  P_IN_READY, 0);
        probe({tag, "_fir_addr"},  P_ADDR, 0);
        probe({tag, "_fir_din"},   P_DIN, 0);
        probe({tag, "_fir_cload"}, P_CLOAD, 1);
        probe({tag, "_fir_dload"}, P_DLOAD, 1);
        probe({tag, "_fir_s"},     P_S, 0);
        probe({tag, "_fir_rstn"},  P_RSTN, 0);
        probe({tag, "_out_data"},  P_ODATA, 0);
        probe({tag, "_out_valid"}, P_OVALID, 0);
        probe({tag, "_busy"},      P_BUSY, 0);
        probe({tag, "_done"},      P_DONE, 0);
    endtask

    // Offer one word; on acceptance record the write the DUT must present.
    task automatic send(input logic [DW-1:0] w, input bit c, input int addr);
        logic rdy;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                wr_q.push_back('{c, addr, int'(w)});
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        #1;
        in_valid = 1'b0;
        probe("send_timeout_in_ready", P_IN_READY, 1);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (3) tick();
        probe_reset_vals("por");
        tick();
        rst = 1'b0;
        tick();

        // Partial load, then reset mid-sequence
        pulse_start();
        probe("started_busy", P_BUSY, 1);
        probe("started_in_ready", P_IN_READY, 1);
        for (int i = 0; i < 10; i++) send(DW'(500 + i), 1'b1, i);
        tick();
        tick();
        rst = 1'b1;
        tick();
        probe_reset_vals("midrst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full load with gaps in the coefficient stream, reload from address 0
        pulse_start();
        for (int i = 0; i < NCOEF; i++) begin
            if (i % 3 == 2) tick();
            send(DW'(100 + i), 1'b1, i);
        end
        probe("in_ready_after_last_coef", P_IN_READY, 0);
        probe("busy_in_load", P_BUSY, 1);
        for (int i = 0; i < NSAMP; i++) send(DW'(7 + i), 1'b0, i);
        probe("in_ready_after_last_samp", P_IN_READY, 0);
        tick();
        probe("run_fir_rstn", P_RSTN, 1);
        probe("run_fir_s", P_S, 1);
        probe("run_in_ready", P_IN_READY, 0);
        probe("run_fir_cload", P_CLOAD, 1);
        probe("run_fir_dload", P_DLOAD, 1);
        probe("run_busy", P_BUSY, 1);
        tick();

        // Result forwarding
        fir_valid = 1'b1;
        fir_dout  = 16'h1234;
        res_q.push_back(16'h1234);
        tick();
        fir_valid = 1'b0;
        probe("fwd_out_valid", P_OVALID, 1);
        tick();
        probe("fwd_out_valid_clear", P_OVALID, 0);
        tick();

        // Completion with coincident result
        fir_valid = 1'b1;
        fir_Done  = 1'b1;
        fir_dout  = 16'h00FF;
        res_q.push_back(16'h00FF);
        done_q.push_back(1'b1);
        tick();
        fir_valid = 1'b0;
        fir_Done  = 1'b0;
        probe("fin_fir_s", P_S, 0);
        probe("fin_fir_rstn", P_RSTN, 0);
        probe("fin_done", P_DONE, 1);
        probe("fin_busy", P_BUSY, 1);
        tick();
        probe("idle_busy", P_BUSY, 0);
        probe("idle_done", P_DONE, 0);
        probe("idle_out_valid", P_OVALID, 0);
        tick();

        // Protocol abuse: FIR handshakes during LOAD_C, start during LOAD_I
        pulse_start();
        for (int i = 0; i < 5; i++) send(DW'(200 + i), 1'b1, i);
        fir_valid = 1'b1;
        fir_Done  = 1'b1;
        fir_dout  = 16'hBEEF;
        tick();
        fir_valid = 1'b0;
        fir_Done  = 1'b0;
        probe("abuse_c_busy", P_BUSY, 1);
        probe("abuse_c_fir_s", P_S, 0);
        probe("abuse_c_in_ready", P_IN_READY, 1);
        tick();
        probe("abuse_c_out_valid", P_OVALID, 0);
        for (int i = 5; i < NCOEF; i++) send(DW'(200 + i), 1'b1, i);
        for (int i = 0; i < 4; i++) send(DW'(300 + i), 1'b0, i);
        pulse_start();
        probe("abuse_i_busy", P_BUSY, 1);
        probe("abuse_i_in_ready", P_IN_READY, 1);
        for (int i = 4; i < 8; i++) send(DW'(300 + i), 1'b0, i);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe("final_busy", P_BUSY, 0);
        tick();

        end_req = 1'b1;
        repeat (10) tick();
        $display("FAIL end_of_test: monitor did not finish");
        $fatal(1, "monitor did not finish");
    end
endmodule
